hazard_scoreboard: RTL

- Parametrised hazard detection and forwarding-select unit for the pipelined LEGv8 CPU. It replaces the fixed EX/MEM and MEM/WB forwarding compare and the hard-wired load-use stall.
- Holds a shift-register scoreboard of in-flight writers, one entry per pipeline register after decode.
- Each cycle it compares the decode-stage instruction against that scoreboard and produces the stall request and the registered per-operand forwarding selects consumed by EX.
- Generalised in scoreboard depth, source-operand count and load latency. Adds flush handling and stall/flush counters.

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hazard_src_match.sv | 43 ++++
 rtl/hazard_scoreboard.sv | 110 +++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : hazard_pkg                                                       |
// | Purpose : Shared types and constants for the hazard scoreboard.            |
// |           sb_entry_t describes one in-flight writer in the scoreboard.     |
// | Ports   : none (package)                                                   |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package hazard_pkg;

  localparam int ZERO_REG           = 31;  // XZR: never a hazard
  localparam int DEFAULT_DEPTH      = 3;
  localparam int DEFAULT_LOAD_READY = 2;

  // The register field is sized for the widest supported register address.
  // Narrower addresses are zero-extended on entry, which keeps compares exact.
  localparam int RD_MAX_W = 8;

  typedef struct packed {
    logic                valid;  // slot holds a real instruction
    logic                wr;     // writes a register other than XZR
    logic                ld;     // load: data only available late
    logic [RD_MAX_W-1:0] rd;     // destination register
  } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/hazard_src_match.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : hazard_src_match                                                 |
// | Purpose : Finds the youngest scoreboard writer of one source register and |
// |           reports its forwarding select and whether it is a load that is   |
// |           not yet able to forward.                                         |
// | Ports   : entries     in  scoreboard entries 0..DEPTH-2                   |
// |           src         in  source register (zero-extended)                 |
// |           src_en      in  decode valid and this source is read            |
// |           sel         out forwarding select (k+1), 0 when no match        |
// |           load_hazard out youngest match is a load not yet forwardable    |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int LOAD_READY = DEFAULT_LOAD_READY,
  parameter int FSEL_W     = $clog2(DEPTH)
) (
  input  sb_entry_t [DEPTH-2:0] entries,
  input  logic [RD_MAX_W-1:0]   src,
  input  logic                  src_en,
  output logic [FSEL_W-1:0]     sel,
  output logic                  load_hazard
);

  // Scan oldest to youngest so the last hit written is the youngest writer.
  always_comb begin
    sel         = '0;
    load_hazard = 1'b0;
    if (src_en) begin
      for (int k = DEPTH - 2; k >= 0; k--) begin
        if (entries[k].valid && entries[k].wr && (entries[k].rd == src)) begin
          sel         = FSEL_W'(k + 1);
          load_hazard = entries[k].ld && ((k + 1) < LOAD_READY);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : hazard_scoreboard                                                |
// | Purpose : Load-use stall and forwarding-select generation for the LEGv8   |
// |           pipeline, driven by a shift-register scoreboard of writers.     |
// | Ports   : clk          in  clock, rising edge                             |
// |           reset        in  asynchronous active-low reset                  |
// |           id_valid     in  decode slot holds a real instruction           |
// |           id_regwrite  in  decode instruction writes a register          |
// |           id_memread   in  decode instruction is a load                  |
// |           id_rd        in  decode destination register                   |
// |           id_src       in  packed source registers                       |
// |           id_src_used  in  per-source read mask                          |
// |           id_flush     in  decode instruction is squashed                |
// |           stall        out combinational stall request                   |
// |           fwd_sel      out registered per-source forwarding selects      |
// |           stall_cnt    out saturating stall-cycle count                  |
// |           flush_cnt    out saturating flush count                        |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int ZERO_REG   = hazard_pkg::ZERO_REG,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int LOAD_READY = DEFAULT_LOAD_READY,
  parameter int CNT_W      = 16,
  parameter int FSEL_W     = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       id_valid,
  input  logic                       id_regwrite,
  input  logic                       id_memread,
  input  logic [REG_AW-1:0]          id_rd,
  input  logic [NUM_SRC*REG_AW-1:0]  id_src,
  input  logic [NUM_SRC-1:0]         id_src_used,
  input  logic                       id_flush,
  output logic                       stall,
  output logic [NUM_SRC*FSEL_W-1:0]  fwd_sel,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           flush_cnt
);

  // Only entries 0..DEPTH-2 are stored: the writer in entry DEPTH-1 is
  // served by the register file's write-before-read bypass, so nothing
  // ever looks at it.
  sb_entry_t [DEPTH-2:0]       r_entry;
  sb_entry_t                   w_new;
  logic [NUM_SRC-1:0]          w_src_ld;
  logic [NUM_SRC*FSEL_W-1:0]   w_sel;
  logic                        w_advance;

  generate
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      logic [RD_MAX_W-1:0] w_src;
      assign w_src = RD_MAX_W'(id_src[s*REG_AW +: REG_AW]);

      hazard_src_match #(
        .DEPTH      (DEPTH),
        .LOAD_READY (LOAD_READY),
        .FSEL_W     (FSEL_W)
      ) u_match (
        .entries     (r_entry),
        .src         (w_src),
        .src_en      (id_valid && id_src_used[s]),
        .sel         (w_sel[s*FSEL_W +: FSEL_W]),
        .load_hazard (w_src_ld[s])
      );
    end
  endgenerate

  // A squashed instruction never stalls; it just becomes a bubble.
  assign stall     = !id_flush && (|w_src_ld);
  assign w_advance = id_valid && !stall && !id_flush;

  always_comb begin
    w_new       = '0;
    w_new.valid = 1'b1;
    w_new.wr    = id_regwrite && (id_rd != REG_AW'(ZERO_REG));
    w_new.ld    = id_memread;
    w_new.rd    = RD_MAX_W'(id_rd);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_entry   <= '0;
      fwd_sel   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      r_entry[0] <= w_advance ? w_new : '0;
      for (int k = 1; k < DEPTH - 1; k++) begin
        r_entry[k] <= r_entry[k-1];
      end
      // Selects only matter for an instruction that actually enters EX.
      fwd_sel <= w_advance ? w_sel : '0;
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (id_valid && id_flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
